move_sequencer: RTL
===================

MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1000, number of clk cycles a player has to drop before an automatic drop.
REQ-002 Parameter: COLS, default 4, board width; fixed at 4 (16-cell board, 4 rows x 4 columns).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a game from IDLE or DONE.
REQ-006 btn_left / btn_right / btn_drop  input  1 each  one-cycle pulses, already debounced.
REQ-007 in_gameboard  input  16  occupancy from datapath; bit index = row*4 + col, row 0 = bottom; 1 = occupied.
REQ-008 in_game_status  input  2  2'b00 = in progress; any other value = game over.
REQ-009 move_ack  input  1  datapath accepted move_column; single-cycle pulse.
REQ-010 move_valid  output  1  move request; held high until move_ack.
REQ-011 move_column  output  3  column of the request, zero-extended (0-3); stable while move_valid.
REQ-012 cursor_col  output  2  currently highlighted column.
REQ-013 col_full_err  output  1  one-cycle pulse, drop rejected on full column.
REQ-014 timeout  output  1  one-cycle pulse when the turn timer expires.
REQ-015 move_count  output  5  accepted moves this game (0-16).
REQ-016 draw  output  1  high in DONE when board filled with status 2'b00.
REQ-017 seq_state  output  2  IDLE=0, SELECT=1, ISSUE=2, DONE=3.

Function
REQ-018 Column c full iff in_gameboard[12+c] = 1; board full iff in_gameboard[15:12] = 4'b1111.
REQ-019 IDLE: wait for start; start -> SELECT, cursor_col = 0, move_count = 0, timer = 0.
REQ-020 SELECT: btn_right increments cursor_col mod 4 (3 -> 0); btn_left decrements mod 4 (0 -> 3); both in same cycle -> cursor unchanged.
REQ-021 SELECT: btn_drop has priority over left/right in the same cycle and uses the pre-move cursor_col; cursor does not move that cycle.
REQ-022 SELECT: btn_drop on non-full column -> ISSUE next cycle, move_column = cursor_col, move_valid = 1.
REQ-023 SELECT: btn_drop on full column -> col_full_err pulses 1 cycle, remain SELECT, timer keeps counting.
REQ-024 Turn timer: cleared on every entry to SELECT, increments each SELECT cycle; at TIMEOUT_CYCLES-1 without a drop -> timeout pulses, lowest-index non-full column is issued (ISSUE), cursor_col set to that column.
REQ-025 ISSUE: move_valid held high, move_column stable until move_ack; move_ack -> move_valid low next cycle, move_count += 1, back to SELECT.
REQ-026 After ISSUE->SELECT, if move_count = 16 or board full -> DONE with draw = 1 (when in_game_status = 2'b00).
REQ-027 In SELECT or ISSUE, in_game_status != 2'b00 -> DONE next cycle, move_valid low, draw = 0; a move_ack arriving that same cycle is still counted.
REQ-028 DONE: ignore buttons and move_ack; start -> SELECT with fresh game values (REQ-019).
REQ-029 start outside IDLE/DONE is ignored.
REQ-030 move_count saturates at 16.

Reset
REQ-031 reset (sampled at clk edge) overrides all inputs, including mid-ISSUE: seq_state = IDLE, move_valid = 0, move_column = 0, cursor_col = 0, move_count = 0, timer = 0, col_full_err = 0, timeout = 0, draw = 0.

Verification
REQ-032 Reset, start, 5 btn_right -> cursor_col sequence 1,2,3,0,1; 2 btn_left from 0 -> 3,2.
REQ-033 cursor 2, empty board, btn_drop -> next cycle move_valid=1, move_column=2; hold ack off 10 cycles, move_valid stays 1; ack -> move_valid=0, move_count=1, SELECT.
REQ-034 in_gameboard[13]=1, cursor 1, btn_drop -> col_full_err 1-cycle pulse, move_valid stays 0, state SELECT.
REQ-035 TIMEOUT_CYCLES=8, in_gameboard[12]=1, no input 8 cycles -> timeout pulse, move_column=1, cursor_col=1, move_valid=1.
REQ-036 16 accepted moves with status 2'b00 -> DONE, draw=1; separate run with in_game_status=2'b01 during ISSUE -> DONE, move_valid=0, draw=0.
REQ-037 reset asserted while move_valid=1 -> next cycle all outputs at REQ-031 values, seq_state=0.

Source files
------------

// File: rtl/move_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | move_sequencer_if : sequencer <-> board datapath handshake and status    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface move_sequencer_if;
  logic [15:0] in_gameboard;
  logic [1:0]  in_game_status;
  logic        move_ack;
  logic        move_valid;
  logic [2:0]  move_column;

  modport master (
    input  in_gameboard, in_game_status, move_ack,
    output move_valid, move_column
  );

  modport slave (
    output in_gameboard, in_game_status, move_ack,
    input  move_valid, move_column
  );
endinterface
`default_nettype wire

// File: rtl/move_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | move_sequencer : cursor, drop, turn-timer and move handshake controller  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module move_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int COLS           = 4
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         start,
  input  wire logic         btn_left,
  input  wire logic         btn_right,
  input  wire logic         btn_drop,
  move_sequencer_if.master  bus,
  output logic [1:0]        cursor_col,
  output logic              col_full_err,
  output logic              timeout,
  output logic [4:0]        move_count,
  output logic              draw,
  output logic [1:0]        seq_state
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SELECT = 2'd1;
  localparam logic [1:0] c_ISSUE  = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;

  localparam int              c_TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(TIMEOUT_CYCLES - 1);
  localparam int              c_TOP        = COLS * COLS - COLS;
  localparam logic [4:0]      c_MAX_MOVES  = 5'd16;

  logic [1:0]      r_state, w_state_nxt;
  logic [1:0]      r_cursor, w_cursor_nxt;
  logic [1:0]      r_column, w_column_nxt;
  logic [c_TW-1:0] r_timer, w_timer_nxt;
  logic [4:0]      r_count, w_count_nxt;
  logic            r_full_err, w_full_err_nxt;
  logic            r_timeout, w_timeout_nxt;
  logic            r_draw, w_draw_nxt;

  logic [3:0] w_top;
  logic       w_sel_full;
  logic       w_board_full;
  logic       w_game_over;
  logic [1:0] w_low_free;
  logic       w_unused_rows;

  // A column is full exactly when its top-row cell is occupied.
  assign w_top         = bus.in_gameboard[c_TOP +: 4];
  assign w_sel_full    = w_top[r_cursor];
  assign w_board_full  = &w_top;
  assign w_game_over   = |bus.in_game_status;
  assign w_unused_rows = ^bus.in_gameboard[c_TOP-1:0];

  always_comb begin
    w_low_free = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!w_top[i]) w_low_free = 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_cursor   <= 2'd0;
      r_column   <= 2'd0;
      r_timer    <= '0;
      r_count    <= 5'd0;
      r_full_err <= 1'b0;
      r_timeout  <= 1'b0;
      r_draw     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cursor   <= w_cursor_nxt;
      r_column   <= w_column_nxt;
      r_timer    <= w_timer_nxt;
      r_count    <= w_count_nxt;
      r_full_err <= w_full_err_nxt;
      r_timeout  <= w_timeout_nxt;
      r_draw     <= w_draw_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cursor_nxt   = r_cursor;
    w_column_nxt   = r_column;
    w_timer_nxt    = r_timer;
    w_count_nxt    = r_count;
    w_full_err_nxt = 1'b0;
    w_timeout_nxt  = 1'b0;
    w_draw_nxt     = r_draw;
    case (r_state)
      c_IDLE, c_DONE: begin
        if (start) begin
          w_state_nxt  = c_SELECT;
          w_cursor_nxt = 2'd0;
          w_count_nxt  = 5'd0;
          w_timer_nxt  = '0;
          w_draw_nxt   = 1'b0;
        end
      end
      c_SELECT: begin
        if (w_game_over) begin
          w_state_nxt = c_DONE;
          w_draw_nxt  = 1'b0;
        end else if (r_count == c_MAX_MOVES || w_board_full) begin
          w_state_nxt = c_DONE;
          w_draw_nxt  = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
          if (btn_drop && !w_sel_full) begin
            w_state_nxt  = c_ISSUE;
            w_column_nxt = r_cursor;
          end else if (r_timer == c_TIMER_LAST) begin
            // Expired turn: auto-drop into the lowest free column.
            w_timeout_nxt  = 1'b1;
            w_full_err_nxt = btn_drop;
            w_state_nxt    = c_ISSUE;
            w_column_nxt   = w_low_free;
            w_cursor_nxt   = w_low_free;
          end else if (btn_drop) begin
            w_full_err_nxt = 1'b1;
          end else if (btn_right && !btn_left) begin
            w_cursor_nxt = r_cursor + 2'd1;
          end else if (btn_left && !btn_right) begin
            w_cursor_nxt = r_cursor - 2'd1;
          end
        end
      end
      c_ISSUE: begin
        if (bus.move_ack && r_count != c_MAX_MOVES) w_count_nxt = r_count + 5'd1;
        if (w_game_over) begin
          w_state_nxt = c_DONE;
          w_draw_nxt  = 1'b0;
        end else if (bus.move_ack) begin
          w_state_nxt = c_SELECT;
          w_timer_nxt = '0;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    bus.move_valid  = (r_state == c_ISSUE);
    bus.move_column = {1'b0, r_column};
    draw            = (r_state == c_DONE) && r_draw;
    seq_state       = r_state;
    cursor_col      = r_cursor;
    move_count      = r_count;
    col_full_err    = r_full_err;
    timeout         = r_timeout;
  end

endmodule
`default_nettype wire
